// File: rtl/tracer_pkg.sv
// Shared widths, FSM state type and averaging helper for the tracer front end.
// DS_ROUND_EN selects round-half-up averaging; undefined gives a truncating average.
package tracer_pkg;

    localparam int DS_ROW_W = 8;
    localparam int DS_COL_W = 9;
    localparam int PIX_W    = 8;
    localparam int HSUM_W   = 9;
    localparam int VSUM_W   = 10;
    localparam int IN_COL_W = 10;

    typedef enum logic {
        WAIT_SOF,
        RUN
    } ds_state_e;

    // 2x2 mean from the four-pixel sum; the largest sum (1020) cannot overflow after rounding.
    function automatic logic [PIX_W-1:0] ds_average(input logic [VSUM_W-1:0] vsum);
`ifdef DS_ROUND_EN
        logic [VSUM_W-1:0] rounded;
        rounded = vsum + VSUM_W'(2);
        return rounded[VSUM_W-1:2];
`else
        return vsum[VSUM_W-1:2];
`endif
    endfunction

endpackage

// File: rtl/enh_ds_linebuf.sv
// Simple dual-port line buffer holding the even-row horizontal pair sums.
// Synchronous write, registered read with one cycle of latency.
module enh_ds_linebuf
    import tracer_pkg::*;
#(
    parameter int DEPTH  = 320,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [HSUM_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [HSUM_W-1:0] rd_data
);

    // NOTE: the storage array has no reset so it can map onto block or distributed RAM;
    // every entry is written on an even row before any odd row reads it.
    logic [HSUM_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/enh_ds_downsampler.sv
// 2x2 box-average downsampler feeding the enh_ds_* stream of the first tracer segment.
// Averaging mode follows tracer_pkg::ds_average (DS_ROUND_EN selects rounding).
module enh_ds_downsampler
    import tracer_pkg::*;
#(
    parameter int DS_COLS = 320,
    parameter int DS_ROWS = 240
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_areset,
    input  logic                pix_valid,
    input  logic                pix_sof,
    input  logic                pix_eol,
    input  logic [PIX_W-1:0]    pix_data,
    output logic                enh_ds_ena,
    output logic [DS_ROW_W-1:0] enh_ds_row,
    output logic [DS_COL_W-1:0] enh_ds_col,
    output logic [PIX_W-1:0]    enh_ds_data,
    output logic                ds_frame_done,
    output logic                ds_overflow
);

    localparam int                  LB_AW    = $clog2(DS_COLS);
    localparam logic [IN_COL_W-1:0] LAST_PIX = IN_COL_W'(2 * DS_COLS - 1);
    localparam logic [DS_ROW_W-1:0] LAST_ROW = DS_ROW_W'(DS_ROWS - 1);
    localparam logic [DS_COL_W-1:0] LAST_COL = DS_COL_W'(DS_COLS - 1);

    ds_state_e state, state_next;

    logic [IN_COL_W-1:0] in_col;
    logic                line_full;
    logic                row_par;
    logic [DS_ROW_W-1:0] ds_row;
    logic [PIX_W-1:0]    h_reg;

    logic                accept, take, beat_odd, beat_par, beat_full, last_row_eol;
    logic [IN_COL_W-1:0] beat_col;
    logic [DS_ROW_W-1:0] beat_row;
    logic [DS_COL_W-1:0] beat_ds_col;
    logic [HSUM_W-1:0]   hsum, lbuf_rd_data;
    logic [VSUM_W-1:0]   vsum;

    // A sof beat restarts the raster, so its position is forced to row 0, col 0.
    assign accept       = pix_valid & (pix_sof | (state == RUN));
    assign beat_col     = pix_sof ? '0 : in_col;
    assign beat_row     = pix_sof ? '0 : ds_row;
    assign beat_par     = pix_sof ? 1'b0 : row_par;
    assign beat_full    = ~pix_sof & line_full;
    assign take         = accept & ~beat_full;
    assign beat_odd     = beat_col[0];
    assign beat_ds_col  = beat_col[IN_COL_W-1:1];
    assign last_row_eol = accept & pix_eol & beat_par & (beat_row == LAST_ROW);

    assign hsum = {1'b0, h_reg} + {1'b0, pix_data};
    assign vsum = {1'b0, lbuf_rd_data} + {1'b0, hsum};

    enh_ds_linebuf #(
        .DEPTH (DS_COLS),
        .ADDR_W(LB_AW)
    ) u_linebuf (
        .clk    (s_axi_aclk),
        .wr_en  (take & beat_odd & ~beat_par),
        .wr_addr(beat_ds_col[LB_AW-1:0]),
        .wr_data(hsum),
        .rd_en  (take & ~beat_odd),
        .rd_addr(beat_ds_col[LB_AW-1:0]),
        .rd_data(lbuf_rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_SOF: if (pix_valid && pix_sof) state_next = RUN;
            RUN:      if (last_row_eol)         state_next = WAIT_SOF;
            default:  state_next = WAIT_SOF;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            in_col        <= '0;
            line_full     <= 1'b0;
            row_par       <= 1'b0;
            ds_row        <= '0;
            h_reg         <= '0;
            enh_ds_ena    <= 1'b0;
            enh_ds_row    <= '0;
            enh_ds_col    <= '0;
            enh_ds_data   <= '0;
            ds_frame_done <= 1'b0;
            ds_overflow   <= 1'b0;
        end else begin
            enh_ds_ena    <= 1'b0;
            ds_frame_done <= 1'b0;
            if (accept) begin
                ds_overflow <= (~pix_sof & ds_overflow) | beat_full;
                if (pix_eol) begin
                    in_col    <= '0;
                    line_full <= 1'b0;
                    row_par   <= ~beat_par;
                    ds_row    <= beat_par ? beat_row + 1'b1 : beat_row;
                end else begin
                    // line_full stands in for in_col == 2*DS_COLS, which 10 bits cannot hold at 512.
                    in_col    <= beat_full ? in_col : beat_col + 1'b1;
                    line_full <= beat_full | (beat_col == LAST_PIX);
                    row_par   <= beat_par;
                    ds_row    <= beat_row;
                end
                if (take && !beat_odd) begin
                    h_reg <= pix_data;
                end
                if (take && beat_odd && beat_par) begin
                    enh_ds_ena    <= 1'b1;
                    enh_ds_row    <= beat_row;
                    enh_ds_col    <= beat_ds_col;
                    enh_ds_data   <= ds_average(vsum);
                    ds_frame_done <= (beat_row == LAST_ROW) && (beat_ds_col == LAST_COL);
                end
            end
        end
    end

endmodule
